delay_tdc_monitor: RTL
======================

DELAY_TDC_MONITOR -- requirements
Module: delay_tdc_monitor

Interface
REQ-001 Parameter N_TAPS, default 16: number of delay-line taps per channel.
REQ-002 Parameter N_CH, default 2: number of independent delay-line channels.
REQ-003 Parameter AVG_LOG2, default 2: log2 of the number of samples averaged per measurement (S = 2^AVG_LOG2).
REQ-004 Derived constants: CNT_W = clog2(N_TAPS+1); CH_W = max(1, clog2(N_CH)).
REQ-005 clk  in  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous and active-low.
REQ-007 taps  in  N_CH*N_TAPS  asynchronous thermometer codes; channel c occupies bits [c*N_TAPS +: N_TAPS]; bit 0 is the first tap.
REQ-008 start  in  1  measurement request; sampled only in IDLE.
REQ-009 cont  in  1  continuous mode: re-arm automatically after each result.
REQ-010 ch_sel  in  CH_W  channel to measure; latched on accepted start and at each continuous re-arm.
REQ-011 thresh  in  CNT_W  alarm threshold.
REQ-012 alarm_clr  in  1  clears the alarm.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 result  out  CNT_W  averaged tap count; holds its value until the next DONE.
REQ-015 result_valid  out  1  one-cycle pulse in DONE.
REQ-016 alarm  out  1  sticky low-margin flag.
REQ-017 bubble_err  out  1  sticky non-thermometer-code flag.

Function
REQ-018 taps SHALL pass through a 2-flop synchronizer on every bit before any use.
REQ-019 Sample count = number of consecutive ones starting at bit 0, stopping at the first zero (range 0..N_TAPS).
REQ-020 FSM states: IDLE, SETTLE, SAMPLE, DONE.
REQ-021 IDLE -> SETTLE when start=1; ch_sel latched in the same cycle.
REQ-022 SETTLE lasts exactly 2 cycles, then -> SAMPLE with accumulator cleared.
REQ-023 SAMPLE lasts exactly S cycles; each cycle adds the count of the latched channel to an accumulator of width CNT_W+AVG_LOG2, which cannot overflow.
REQ-024 DONE lasts 1 cycle: result = accumulator >> AVG_LOG2 (truncating); result_valid = 1.
REQ-025 DONE -> SETTLE if cont=1 in DONE (ch_sel re-latched), else -> IDLE.
REQ-026 result_valid SHALL rise exactly 3+S cycles after the cycle in which start was sampled (7 for defaults).
REQ-027 start while busy=1 SHALL be ignored with no queuing.
REQ-028 ch_sel >= N_CH on latch SHALL select channel 0.
REQ-029 alarm is set in DONE when result < thresh; alarm_clr clears it; simultaneous set and clear -> set wins.
REQ-030 bubble_err is set in any SAMPLE cycle where the selected code has a 1 above a 0; cleared on an accepted start; set in the same cycle as the clear -> set wins.
REQ-031 Changing cont, thresh or ch_sel mid-measurement SHALL NOT affect the measurement in progress, except cont as evaluated in DONE.

Reset
REQ-032 rst_n=0 at a rising edge SHALL force: state IDLE, busy 0, result 0, result_valid 0, alarm 0, bubble_err 0, accumulator 0, synchronizer flops 0, latched channel 0.
REQ-033 Reset in any state, including mid-SAMPLE, SHALL abort the measurement with no result_valid pulse.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, the SETTLE length constant (2), and the clog2-based width helpers.
REQ-035 One sub-module, therm_decode (N_TAPS-bit code -> CNT_W count + bubble flag, combinational), SHALL be instantiated once on the selected channel.

Verification
REQ-036 Defaults; ch0 taps=0x00FF steady; start pulse -> busy 1 the next cycle, result_valid 7 cycles after start, result=8.
REQ-037 ch1 alternating 0x00FF/0x03FF on successive sample cycles -> sum 36, result=9; 0xFFFF steady -> result=16.
REQ-038 thresh=9, result=8 -> alarm=1 and stays 1 across a later result of 12; alarm_clr pulse -> 0; alarm_clr in the same cycle as a DONE with result 8 -> alarm stays 1.
REQ-039 taps=0x00F7 -> result=3, bubble_err=1; next accepted start clears it to 0.
REQ-040 cont=1 -> result_valid every 7 cycles (2+4+1); start pulsed while busy -> no extra measurement.
REQ-041 rst_n=0 during the 2nd SAMPLE cycle -> all outputs at reset values, no result_valid; a new start then gives normal 7-cycle latency.

Source files
------------

// File: rtl/delay_tdc_monitor_pkg.sv
// Shared types and width helpers for the delay-line TDC monitor.
package delay_tdc_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int SETTLE_LEN = 2;

  function automatic int cnt_width(input int n_taps);
    return $clog2(n_taps + 1);
  endfunction

  function automatic int ch_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/delay_tdc_monitor_therm_decode.sv
// Thermometer decoder: run length of ones from bit 0, plus a flag for any 1 above a 0.
module therm_decode
  import delay_tdc_monitor_pkg::*;
#(
  parameter int N_TAPS = 16,
  localparam int CNT_W = cnt_width(N_TAPS)
) (
  input  logic [N_TAPS-1:0] code,
  output logic [CNT_W-1:0]  count,
  output logic              bubble
);

  logic seen_zero;

  // NOTE: every variable gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count     = '0;
    bubble    = 1'b0;
    seen_zero = 1'b0;
    for (int i = 0; i < N_TAPS; i++) begin
      if (!code[i]) begin
        seen_zero = 1'b1;
      end else if (seen_zero) begin
        bubble = 1'b1;
      end else begin
        count = CNT_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/delay_tdc_monitor.sv
// Delay-line TDC monitor: synchronizes tap codes, averages 2^AVG_LOG2 samples of one
// channel, and raises sticky low-margin and bubble flags.
module delay_tdc_monitor
  import delay_tdc_monitor_pkg::*;
#(
  parameter int N_TAPS   = 16,
  parameter int N_CH     = 2,
  parameter int AVG_LOG2 = 2,
  localparam int CNT_W   = cnt_width(N_TAPS),
  localparam int CH_W    = ch_width(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH*N_TAPS-1:0] taps,
  input  logic                   start,
  input  logic                   cont,
  input  logic [CH_W-1:0]        ch_sel,
  input  logic [CNT_W-1:0]       thresh,
  input  logic                   alarm_clr,
  output logic                   busy,
  output logic [CNT_W-1:0]       result,
  output logic                   result_valid,
  output logic                   alarm,
  output logic                   bubble_err
);

  localparam int S      = 1 << AVG_LOG2;
  localparam int ACC_W  = CNT_W + AVG_LOG2;
  localparam int SAMP_W = AVG_LOG2 + 1;

  state_t                   state;
  logic [N_CH*N_TAPS-1:0]   sync1, sync2;
  logic [CH_W-1:0]          ch_q;
  logic [CNT_W-1:0]         thresh_q;
  logic [1:0]               settle_cnt;
  logic [SAMP_W-1:0]        samp_cnt;
  logic [ACC_W-1:0]         acc;
  logic [ACC_W-1:0]         acc_next;
  logic [CNT_W-1:0]         avg_next;
  logic [N_TAPS-1:0]        sel_code;
  logic [CNT_W-1:0]         count;
  logic                     bubble;
  logic                     last_sample;
  logic                     alarm_set;
  logic                     bubble_set;
  logic                     bubble_clr;

  // Out-of-range channel requests fall back to channel 0.
  function automatic logic [CH_W-1:0] clamp_ch(input logic [CH_W-1:0] c);
    return (int'(c) < N_CH) ? c : '0;
  endfunction

  always_comb begin
    sel_code = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_q == CH_W'(c)) sel_code = sync2[c*N_TAPS +: N_TAPS];
    end
  end

  therm_decode #(.N_TAPS(N_TAPS)) u_decode (
    .code   (sel_code),
    .count  (count),
    .bubble (bubble)
  );

  assign acc_next    = acc + ACC_W'(count);
  assign avg_next    = CNT_W'(acc_next >> AVG_LOG2);
  assign last_sample = (state == SAMPLE) && (samp_cnt == SAMP_W'(S - 1));
  assign busy        = (state != IDLE);

  // Alarm is asserted on the edge entering DONE and again while in DONE, so a clear
  // coinciding with either edge of the result cycle loses.
  assign alarm_set  = (last_sample && (avg_next < thresh_q)) ||
                      ((state == DONE) && (result < thresh_q));
  assign bubble_set = (state == SAMPLE) && bubble;
  assign bubble_clr = (state == IDLE) && start;

  // NOTE: all sequential state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1        <= '0;
      sync2        <= '0;
      state        <= IDLE;
      ch_q         <= '0;
      thresh_q     <= '0;
      settle_cnt   <= '0;
      samp_cnt     <= '0;
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      alarm        <= 1'b0;
      bubble_err   <= 1'b0;
    end else begin
      sync1        <= taps;
      sync2        <= sync1;
      result_valid <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            ch_q       <= clamp_ch(ch_sel);
            thresh_q   <= thresh;
          end
        end
        SETTLE: begin
          if (settle_cnt == 2'(SETTLE_LEN - 1)) begin
            state    <= SAMPLE;
            acc      <= '0;
            samp_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 2'd1;
          end
        end
        SAMPLE: begin
          acc      <= acc_next;
          samp_cnt <= samp_cnt + SAMP_W'(1);
          if (last_sample) begin
            state        <= DONE;
            result       <= avg_next;
            result_valid <= 1'b1;
          end
        end
        DONE: begin
          if (cont) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            ch_q       <= clamp_ch(ch_sel);
            thresh_q   <= thresh;
          end else begin
            state <= IDLE;
          end
        end
      endcase

      if (alarm_set)      alarm <= 1'b1;
      else if (alarm_clr) alarm <= 1'b0;

      if (bubble_set)      bubble_err <= 1'b1;
      else if (bubble_clr) bubble_err <= 1'b0;
    end
  end

endmodule
